// File: rtl/aes_req_arbiter_if.sv
// Bus between the request arbiter and the shared aes core: command fields, byte stream, ack.
// No storage; every signal is a plain wire between the two ends.
// The stream uses valid/ready and the ack uses ack_valid/ack_ready; the core side may stall either one.
interface aes_req_arbiter_if;
  logic [1:0]  aes_opcode;
  logic [1:0]  aes_source_id;
  logic [1:0]  aes_dest_id;
  logic        aes_encdec;
  logic [23:0] aes_addr;
  logic [7:0]  aes_data_in;
  logic        aes_valid_in;
  logic        aes_ready_in;
  logic        aes_ack_ready;
  logic        aes_ack_valid;
  logic [1:0]  aes_module_source_id;

  // Arbiter side
  modport master (
    output aes_opcode, aes_source_id, aes_dest_id, aes_encdec, aes_addr,
    output aes_data_in, aes_valid_in, aes_ack_ready,
    input  aes_ready_in, aes_ack_valid, aes_module_source_id
  );

  // Core side
  modport slave (
    input  aes_opcode, aes_source_id, aes_dest_id, aes_encdec, aes_addr,
    input  aes_data_in, aes_valid_in, aes_ack_ready,
    output aes_ready_in, aes_ack_valid, aes_module_source_id
  );
endinterface

// File: rtl/aes_req_arbiter.sv
// Two-requester round-robin arbiter that sequences one command, its byte stream and its ack through the aes core.
// Grant 1 cycle after req; bytes pass through combinationally; done/err pulse 1 cycle after the ack or the stall limit.
// req_ready of the granted requester mirrors aes_ready_in; a stall of TIMEOUT cycles aborts the transaction.
module aes_req_arbiter #(
  parameter logic [1:0]  SRC_ID0 = 2'b00,
  parameter logic [1:0]  SRC_ID1 = 2'b01,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned TW      = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [3:0]        req_opcode,
  input  logic [3:0]        req_dest_id,
  input  logic [1:0]        req_encdec,
  input  logic [47:0]       req_addr,
  input  logic [15:0]       req_data,
  input  logic [1:0]        req_valid,
  input  logic [1:0]        req_last,
  output logic [1:0]        req_ready,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
  output logic [1:0]        err,
  output logic              busy,
  aes_req_arbiter_if.master aes
);

  typedef enum logic [1:0] {IDLE, STREAM, WAIT_ACK} state_t;

  state_t        state_q, state_d;
  logic          ptr_q, ptr_d;     // requester favoured at the next arbitration
  logic          g_q, g_d;         // index of the granted requester
  logic [1:0]    gnt_q, gnt_d;
  logic [1:0]    done_q, done_d;
  logic [1:0]    err_q, err_d;
  logic [TW-1:0] wd_q, wd_d;       // cycles since the last forward progress
  logic          load;

  logic [1:0]    op_q, dst_q, sid_q;
  logic          enc_q;
  logic [23:0]   addr_q;

  logic          win, beat, ack_hit, wd_expire, finish;

  assign win       = req[ptr_q] ? ptr_q : ~ptr_q;
  assign beat      = (state_q == STREAM) && req_valid[g_q] && aes.aes_ready_in;
  assign ack_hit   = (state_q == WAIT_ACK) && aes.aes_ack_valid &&
                     (aes.aes_module_source_id == sid_q);
  // The counter would reach TIMEOUT on this edge; zero TIMEOUT never expires.
  assign wd_expire = (TIMEOUT != 0) && (wd_q == TW'(TIMEOUT - 1));

  // Next-state, pulse and datapath-steering decisions
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    g_d     = g_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = '0;
    wd_d    = wd_q;
    load    = 1'b0;
    finish  = 1'b0;
    req_ready         = '0;
    aes.aes_valid_in  = 1'b0;
    aes.aes_data_in   = '0;
    aes.aes_ack_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          load    = 1'b1;
          g_d     = win;
          gnt_d   = win ? 2'b10 : 2'b01;
          wd_d    = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        aes.aes_valid_in = req_valid[g_q];
        aes.aes_data_in  = g_q ? req_data[15:8] : req_data[7:0];
        req_ready[g_q]   = aes.aes_ready_in;
        // A transferred beat outranks an expiring watchdog.
        if (beat) begin
          wd_d = '0;
          if (req_last[g_q]) state_d = WAIT_ACK;
        end else if (wd_expire) begin
          err_d[g_q] = 1'b1;
          finish     = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      WAIT_ACK: begin
        aes.aes_ack_ready = 1'b1;
        // Mismatched acks are swallowed here simply by not matching.
        if (ack_hit) begin
          done_d[g_q] = 1'b1;
          finish      = 1'b1;
        end else if (wd_expire) begin
          err_d[g_q] = 1'b1;
          finish     = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (finish) begin
      gnt_d   = '0;
      ptr_d   = ~g_q;
      wd_d    = '0;
      state_d = IDLE;
    end
  end

  // Control state, round-robin pointer, grant, pulses and watchdog
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      g_q     <= 1'b0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
    end
  end

  // Command fields captured at grant and held until the next grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      dst_q  <= '0;
      enc_q  <= 1'b0;
      addr_q <= '0;
      sid_q  <= '0;
    end else if (load) begin
      op_q   <= win ? req_opcode[3:2]   : req_opcode[1:0];
      dst_q  <= win ? req_dest_id[3:2]  : req_dest_id[1:0];
      enc_q  <= win ? req_encdec[1]     : req_encdec[0];
      addr_q <= win ? req_addr[47:24]   : req_addr[23:0];
      sid_q  <= win ? SRC_ID1           : SRC_ID0;
    end
  end

  assign gnt               = gnt_q;
  assign done              = done_q;
  assign err               = err_q;
  assign busy              = (state_q != IDLE);
  assign aes.aes_opcode    = op_q;
  assign aes.aes_source_id = sid_q;
  assign aes.aes_dest_id   = dst_q;
  assign aes.aes_encdec    = enc_q;
  assign aes.aes_addr      = addr_q;

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Directed bench for aes_req_arbiter with a transaction-level reference model and per-cycle compare.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Requester byte sources advance only on an observed valid&&ready handshake.
module tb_aes_req_arbiter;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  req = '0;
  logic [3:0]  req_opcode = '0;
  logic [3:0]  req_dest_id = '0;
  logic [1:0]  req_encdec = '0;
  logic [47:0] req_addr = '0;
  logic [15:0] req_data;
  logic [1:0]  req_valid;
  logic [1:0]  req_last;
  logic [1:0]  req_ready, gnt, done, err;
  logic        busy;
  logic        chk_en = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  aes_req_arbiter_if bus ();

  aes_req_arbiter #(.SRC_ID0(2'b00), .SRC_ID1(2'b01), .TIMEOUT(TO), .TW(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_opcode(req_opcode), .req_dest_id(req_dest_id),
    .req_encdec(req_encdec), .req_addr(req_addr), .req_data(req_data), .req_valid(req_valid),
    .req_last(req_last), .req_ready(req_ready), .gnt(gnt), .done(done), .err(err),
    .busy(busy), .aes(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- requester byte sources: {last, data} ----------------
  logic [8:0] srcq0[$];
  logic [8:0] srcq1[$];
  logic [1:0] hs;

  initial begin
    req_valid = '0; req_data = '0; req_last = '0;
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      if (hs[0] && srcq0.size() > 0) void'(srcq0.pop_front());
      if (hs[1] && srcq1.size() > 0) void'(srcq1.pop_front());
      if (srcq0.size() > 0) begin
        req_valid[0] = 1'b1; req_data[7:0] = srcq0[0][7:0]; req_last[0] = srcq0[0][8];
      end else begin
        req_valid[0] = 1'b0; req_last[0] = 1'b0;
      end
      if (srcq1.size() > 0) begin
        req_valid[1] = 1'b1; req_data[15:8] = srcq1[0][7:0]; req_last[1] = srcq1[0][8];
      end else begin
        req_valid[1] = 1'b0; req_last[1] = 1'b0;
      end
    end
  end

  // ---------------- reference model (one owner or none) ----------------
  int          m_owner = -1;   // -1: no transaction in flight
  bit          m_ack = 1'b0;   // all bytes sent, awaiting ack
  int          m_ptr = 0;
  int          m_cyc = 0;
  int          m_prog = 0;     // edge number of the last forward progress
  logic [1:0]  m_done = '0, m_err = '0, m_op = '0, m_dst = '0, m_sid = '0;
  logic        m_enc = 1'b0;
  logic [23:0] m_addr = '0;

  initial begin
    int  w;
    bit  fin;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_owner = -1; m_ack = 0; m_ptr = 0; m_cyc = 0; m_prog = 0;
        m_done = '0; m_err = '0; m_op = '0; m_dst = '0; m_sid = '0; m_enc = 0; m_addr = '0;
      end else begin
        m_done = '0; m_err = '0; m_cyc++;
        if (m_owner < 0) begin
          if (req != 2'b00) begin
            w = req[m_ptr] ? m_ptr : 1 - m_ptr;
            m_owner = w; m_ack = 0; m_prog = m_cyc;
            m_op = req_opcode[2*w +: 2]; m_dst = req_dest_id[2*w +: 2];
            m_enc = req_encdec[w]; m_addr = req_addr[24*w +: 24];
            m_sid = (w == 1) ? 2'b01 : 2'b00;
          end
        end else begin
          fin = 0;
          if (!m_ack) begin
            if (req_valid[m_owner] && bus.aes_ready_in) begin
              m_prog = m_cyc;
              if (req_last[m_owner]) m_ack = 1;
            end
          end else if (bus.aes_ack_valid && bus.aes_module_source_id == m_sid) begin
            m_done[m_owner] = 1'b1; fin = 1;
          end
          if (!fin && (m_cyc - m_prog) == TO) begin
            m_err[m_owner] = 1'b1; fin = 1;
          end
          if (fin) begin
            m_ptr = 1 - m_owner; m_owner = -1;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare and logs ----------------
  logic [3:0] glog[$];   // {gnt, aes_source_id} at each new grant
  logic [7:0] blog[$];   // bytes transferred to the core
  logic [1:0] prev_gnt = '0;

  initial begin
    logic [1:0] e_gnt, e_rdy;
    logic       e_vld, e_ackr;
    wait (chk_en);
    forever begin
      @(negedge clk);
      e_gnt = '0; e_rdy = '0; e_vld = 0; e_ackr = 0;
      if (m_owner >= 0) begin
        e_gnt = (m_owner == 1) ? 2'b10 : 2'b01;
        if (m_ack) e_ackr = 1;
        else begin
          e_vld = req_valid[m_owner];
          e_rdy[m_owner] = bus.aes_ready_in;
        end
      end
      check("gnt", 32'(gnt), 32'(e_gnt));
      check("busy", 32'(busy), 32'(m_owner >= 0));
      check("done", 32'(done), 32'(m_done));
      check("err", 32'(err), 32'(m_err));
      check("req_ready", 32'(req_ready), 32'(e_rdy));
      check("aes_valid_in", 32'(bus.aes_valid_in), 32'(e_vld));
      check("aes_ack_ready", 32'(bus.aes_ack_ready), 32'(e_ackr));
      check("aes_opcode", 32'(bus.aes_opcode), 32'(m_op));
      check("aes_dest_id", 32'(bus.aes_dest_id), 32'(m_dst));
      check("aes_encdec", 32'(bus.aes_encdec), 32'(m_enc));
      check("aes_addr", 32'(bus.aes_addr), 32'(m_addr));
      check("aes_source_id", 32'(bus.aes_source_id), 32'(m_sid));
      if (e_vld) check("aes_data_in", 32'(bus.aes_data_in), 32'(req_data[8*m_owner +: 8]));
      if (gnt != 2'b00 && prev_gnt == 2'b00) glog.push_back({gnt, bus.aes_source_id});
      if (bus.aes_valid_in && bus.aes_ready_in) blog.push_back(bus.aes_data_in);
      prev_gnt = gnt;
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input int budget);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (gnt == 2'b00 && k < budget);
    check("gnt_seen", 32'(|gnt), 32'd1);
  endtask

  task automatic wait_ack_ready(input int budget);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.aes_ack_ready && k < budget);
    check("ack_ready_seen", 32'(bus.aes_ack_ready), 32'd1);
  endtask

  task automatic do_ack(input logic [1:0] sid);
    tick();
    bus.aes_ack_valid = 1'b1;
    bus.aes_module_source_id = sid;
    tick();
    bus.aes_ack_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete at %0t", $time);
    $fatal(1, "bench timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [3:0] eg [3] = '{4'b0100, 4'b1001, 4'b0100};
    logic [7:0] eb3 [3] = '{8'h10, 8'h21, 8'h12};
    logic [7:0] eb_s [3] = '{8'hAA, 8'hBB, 8'hCC};
    logic [7:0] eb_bp [4] = '{8'h31, 8'h32, 8'h33, 8'h34};

    bus.aes_ready_in = 1'b1;
    bus.aes_ack_valid = 1'b0;
    bus.aes_module_source_id = 2'b00;
    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ack_ready", 32'(bus.aes_ack_ready), 32'd0);
    rst_n = 1'b1;

    // Contention: both requesters held, one byte each
    tick();
    req = 2'b11; req_opcode = 4'b10_01; req_dest_id = 4'b11_00; req_encdec = 2'b10;
    req_addr = {24'hB1B1B1, 24'hA0A0A0};
    srcq0.push_back({1'b1, 8'h10}); srcq0.push_back({1'b1, 8'h12});
    srcq1.push_back({1'b1, 8'h21});
    for (int k = 0; k < 3; k++) begin
      wait_ack_ready(40);
      do_ack((k == 1) ? 2'b01 : 2'b00);
    end
    req = 2'b00;
    @(negedge clk);
    check("rr_grant_count", 32'(glog.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < glog.size()) check("rr_grant_order", 32'(glog[i]), 32'(eg[i]));
    check("rr_byte_count", 32'(blog.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < blog.size()) check("rr_bytes", 32'(blog[i]), 32'(eb3[i]));

    // Single request from r0
    blog.delete();
    tick();
    req = 2'b01; req_opcode = 4'b00_11; req_dest_id = 4'b00_10; req_encdec = 2'b01;
    req_addr = {24'h0, 24'h000123};
    srcq0.push_back({1'b0, 8'hAA}); srcq0.push_back({1'b0, 8'hBB}); srcq0.push_back({1'b1, 8'hCC});
    @(negedge clk);
    check("gnt_before_edge", 32'(gnt), 32'd0);
    @(negedge clk);
    check("gnt_latency", 32'(gnt), 32'b01);
    tick();
    req = 2'b00;
    wait_ack_ready(40);
    check("single_byte_count", 32'(blog.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < blog.size()) check("single_bytes", 32'(blog[i]), 32'(eb_s[i]));
    check("single_opcode", 32'(bus.aes_opcode), 32'b11);
    check("single_addr", 32'(bus.aes_addr), 32'h000123);
    check("single_sid", 32'(bus.aes_source_id), 32'b00);
    tick();
    do_ack(2'b00);
    @(negedge clk);
    check("single_done", 32'(done), 32'b01);
    check("single_busy_after", 32'(busy), 32'd0);

    // Backpressure on r1
    blog.delete();
    tick();
    req = 2'b10;
    srcq1.push_back({1'b0, 8'h31}); srcq1.push_back({1'b0, 8'h32});
    srcq1.push_back({1'b0, 8'h33}); srcq1.push_back({1'b1, 8'h34});
    wait_gnt(10);
    tick();
    req = 2'b00;
    bus.aes_ready_in = 1'b0;
    repeat (5) tick();
    bus.aes_ready_in = 1'b1;
    wait_ack_ready(40);
    check("bp_byte_count", 32'(blog.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < blog.size()) check("bp_bytes", 32'(blog[i]), 32'(eb_bp[i]));
    do_ack(2'b01);
    @(negedge clk);
    check("bp_done", 32'(done), 32'b10);

    // Wrong ack followed by the matching one
    tick();
    req = 2'b01;
    srcq0.push_back({1'b1, 8'h44});
    wait_gnt(10);
    tick();
    req = 2'b00;
    wait_ack_ready(40);
    do_ack(2'b01);
    @(negedge clk);
    check("wrong_ack_no_done", 32'(done), 32'd0);
    check("wrong_ack_busy", 32'(busy), 32'd1);
    do_ack(2'b00);
    @(negedge clk);
    check("right_ack_done", 32'(done), 32'b01);

    // Timeout while waiting for an ack on r1
    tick();
    req = 2'b10;
    srcq1.push_back({1'b1, 8'h55});
    wait_gnt(10);
    tick();
    req = 2'b00;
    wait_ack_ready(40);
    for (int k = 0; k < TO - 1; k++) begin
      @(negedge clk);
      check("no_early_err", 32'(err), 32'd0);
    end
    @(negedge clk);
    check("err_after_timeout", 32'(err), 32'b10);
    check("idle_after_err", 32'(busy), 32'd0);
    tick();
    req = 2'b11;
    srcq0.push_back({1'b1, 8'h66});
    @(negedge clk);
    @(negedge clk);
    check("ptr_after_timeout", 32'(gnt), 32'b01);
    tick();
    req = 2'b00;
    wait_ack_ready(40);
    do_ack(2'b00);
    @(negedge clk);

    // Reset during STREAM
    tick();
    bus.aes_ready_in = 1'b0;
    req = 2'b10;
    srcq1.push_back({1'b0, 8'h77}); srcq1.push_back({1'b1, 8'h78});
    wait_gnt(10);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_gnt", 32'(gnt), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_req_ready", 32'(req_ready), 32'd0);
    check("arst_valid", 32'(bus.aes_valid_in), 32'd0);
    check("arst_opcode", 32'(bus.aes_opcode), 32'd0);
    check("arst_addr", 32'(bus.aes_addr), 32'd0);
    check("arst_done_err", 32'({done, err}), 32'd0);
    srcq1.delete();
    req = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.aes_ready_in = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_no_pulse", 32'({done, err}), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/aes_req_arbiter.md
Name: aes_req_arbiter

Overview:
Two-requester round-robin arbiter and transaction sequencer in front of the shared aes core. It latches one requester's command fields (opcode, dest_id, encdec, addr) and stamps that requester's source_id. It streams the requester's bytes over the aes valid/ready bus, then waits for the matching ack before releasing the core. A watchdog aborts transactions that stall.

Parameters:
SRC_ID0, 2'b00, source_id driven to the core for requester 0
SRC_ID1, 2'b01, source_id driven to the core for requester 1
TIMEOUT, 1024, stall cycles before abort; 0 disables the watchdog
TW, 11, watchdog counter width; must satisfy 2^TW > TIMEOUT

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req  in  2  per-requester transaction request
req_opcode  in  4  {r1,r0} 2-bit opcodes
req_dest_id  in  4  {r1,r0} 2-bit destination ids
req_encdec  in  2  per-requester encdec
req_addr  in  48  {r1,r0} 24-bit addresses
req_data  in  16  {r1,r0} payload bytes
req_valid  in  2  payload byte valid
req_last  in  2  marks final payload byte
req_ready  out  2  payload byte accepted
gnt  out  2  one-hot grant
done  out  2  one-cycle completion pulse
err  out  2  one-cycle timeout pulse
aes_opcode  out  2  to core
aes_source_id  out  2  to core
aes_dest_id  out  2  to core
aes_encdec  out  1  to core
aes_addr  out  24  to core
aes_data_in  out  8  to core
aes_valid_in  out  1  to core
aes_ready_in  in  1  from core
aes_ack_ready  out  1  to core
aes_ack_valid  in  1  from core
aes_module_source_id  in  2  source id carried with the ack
busy  out  1  high whenever the state is not IDLE

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous and active-low.
- Reset values: state=IDLE, rr pointer=0, watchdog=0. gnt, done, err, busy, aes_valid_in and aes_ack_ready are 0. All latched command fields are 0. req_ready=0.
- States: IDLE, STREAM, WAIT_ACK.
- IDLE:
  - If any req bit is high, pick the winner. The pointer's requester wins if it requests; otherwise the other requester wins.
  - On the next edge: set gnt one-hot and latch the winner's opcode, dest_id, encdec and addr. Latch source_id = SRC_ID0 or SRC_ID1. Go to STREAM.
  - Grant latency is 1 cycle from req.
- Command outputs (aes_opcode, aes_source_id, aes_dest_id, aes_encdec, aes_addr):
  - Registered; stable from grant until the return to IDLE.
  - Changes to req_* command inputs after the grant are ignored.
- STREAM (g = granted index):
  - aes_valid_in = req_valid[g].
  - aes_data_in = req_data[g] (combinational mux).
  - req_ready[g] = aes_ready_in. The other req_ready bit is 0.
  - A beat transfers when aes_valid_in && aes_ready_in.
  - A beat with req_last[g] moves to WAIT_ACK on the next edge.
- WAIT_ACK:
  - aes_ack_ready=1; aes_valid_in=0.
  - Ack handshake is aes_ack_valid && aes_ack_ready.
  - If aes_module_source_id equals the latched source_id: pulse done[g] for 1 cycle, clear gnt, toggle the pointer to the other requester, go to IDLE.
  - Acks with a mismatched source id are consumed and ignored.
- Watchdog:
  - Reset to 0 on entering STREAM and on every transferred beat.
  - Otherwise increments each cycle in STREAM and WAIT_ACK.
  - On reaching TIMEOUT (when nonzero): pulse err[g], clear gnt, toggle the pointer, go to IDLE.
- Simultaneous events:
  - A matching ack in the same cycle the watchdog hits TIMEOUT resolves as done, not err.
  - A last beat in the same cycle as the timeout resolves as a transfer; the watchdog resets and the block moves to WAIT_ACK.
- Requester behaviour mid-transaction: dropping req after the grant does not abort; the transaction runs to ack or timeout.
- Back-to-back: a new grant can issue in the cycle after the return to IDLE. There is at least 1 IDLE cycle between transactions.
- Reset mid-transaction: everything returns to reset values immediately; no done or err pulse is produced.

Test Plan:
- Single request: req=01, opcode0=2'b11, dest0=2'b10, addr0=24'h000123, 3 bytes AA,BB,CC (last on CC), core always ready, ack with source id 00 2 cycles later. Expect: gnt=01 one cycle after req; aes_data_in sequence AA,BB,CC; aes_opcode=11, aes_addr=000123, aes_source_id=00; done[0] pulse; busy low afterwards.
- Contention: req=11 held continuously, each transaction 1 byte. Expect grants in the order r0, r1, r0. Requester 1's transactions show aes_source_id=01.
- Backpressure: aes_ready_in low for 5 cycles mid-stream, with req_valid held. Expect no byte dropped or duplicated; req_ready[g] follows aes_ready_in.
- Wrong ack: in WAIT_ACK for r0, an ack arrives with source id 01, followed by one with 00. Expect no done on the first ack and done[0] on the second.
- Timeout: TIMEOUT=8, no ack. Expect err[g] exactly 8 cycles after entering WAIT_ACK, then IDLE, and the pointer toggled.
- Reset during STREAM: rst_n pulsed low. Expect all outputs at reset values asynchronously and no done or err pulse.
